reg_file: RTL and testbench

- 32 x DATA_WIDTH integer register file for the RV32I core.
- Sits directly downstream of the writeback result selection. Its write-data port consumes the selected writeback value (ALU result / load data / PC+4), and its read ports feed operand selection and the ALU.
- Two combinational read ports, one clocked write port, x0 hardwired to zero, programmable stack-pointer reset value, dedicated a0 observation output for test programs.

---
 rtl/reg_file.sv | 65 ++++++
 tb/tb_reg_file.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/reg_file.sv
// reg_file: 32 x DATA_WIDTH RV32I integer register file, x0 reads zero, x2 resets to SP_INIT; a0 mirrors x10.
// Latency: reads combinational, write lands on the rising edge; REGFILE_BYPASS_EN forwards WD3 to RD1/RD2 same cycle.
// Backpressure: none, an enabled write is accepted on every clock edge.
module reg_file #(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 5,
    parameter logic [DATA_WIDTH-1:0] SP_INIT    = 32'h0001_FFFC
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  RegWrite,
    input  logic [ADDR_WIDTH-1:0] A1,
    input  logic [ADDR_WIDTH-1:0] A2,
    input  logic [ADDR_WIDTH-1:0] A3,
    input  logic [DATA_WIDTH-1:0] WD3,
    output logic [DATA_WIDTH-1:0] RD1,
    output logic [DATA_WIDTH-1:0] RD2,
    output logic [DATA_WIDTH-1:0] a0
);

    localparam int NREGS = 2 ** ADDR_WIDTH;

    // x0 has no storage; index 0 falls through the read mux default
    logic [DATA_WIDTH-1:0] regs [1:NREGS-1];
    logic [DATA_WIDTH-1:0] rd1_raw;
    logic [DATA_WIDTH-1:0] rd2_raw;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 1; i < NREGS; i++) begin
                regs[i] <= (i == 2) ? SP_INIT : '0;
            end
        end else if (RegWrite) begin
            for (int i = 1; i < NREGS; i++) begin
                if (A3 == i[ADDR_WIDTH-1:0]) begin
                    regs[i] <= WD3;
                end
            end
        end
    end

    always_comb begin
        rd1_raw = '0;
        rd2_raw = '0;
        for (int i = 1; i < NREGS; i++) begin
            if (A1 == i[ADDR_WIDTH-1:0]) rd1_raw = regs[i];
            if (A2 == i[ADDR_WIDTH-1:0]) rd2_raw = regs[i];
        end
    end

`ifdef REGFILE_BYPASS_EN
    logic wr_live;

    // A1 == A3 with A3 != 0 already excludes x0 from forwarding
    assign wr_live = RegWrite && (A3 != '0);
    assign RD1     = (wr_live && (A1 == A3)) ? WD3 : rd1_raw;
    assign RD2     = (wr_live && (A2 == A3)) ? WD3 : rd2_raw;
`else
    assign RD1 = rd1_raw;
    assign RD2 = rd2_raw;
`endif

    assign a0 = regs[10];

endmodule

// File: tb/tb_reg_file.sv
// Scoreboard bench for reg_file: stimulus queues expected outputs, a monitor compares on each sample strobe.
module tb_reg_file;

    localparam logic [31:0] SP = 32'h0001_FFFC;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        RegWrite;
    logic [4:0]  A1, A2, A3;
    logic [31:0] WD3;
    logic [31:0] RD1, RD2, a0;

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } exp_t;

    exp_t sbq[$];
    event sample_ev;
    int   n_checks = 0;
    int   n_fail   = 0;

    reg_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .SP_INIT(SP)) dut (
        .clk(clk), .rst_n(rst_n), .RegWrite(RegWrite),
        .A1(A1), .A2(A2), .A3(A3), .WD3(WD3),
        .RD1(RD1), .RD2(RD2), .a0(a0)
    );

    always #5 clk = ~clk;

    // monitor: drains the scoreboard each time the stimulus declares outputs valid
    initial begin
        exp_t        e;
        logic [31:0] act;
        forever begin
            @(sample_ev);
            while (sbq.size() > 0) begin
                e   = sbq.pop_front();
                act = (e.sel == 0) ? RD1 : (e.sel == 1) ? RD2 : a0;
                n_checks++;
                if (act !== e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
                end
            end
        end
    end

    task automatic push_exp(input string name, input int sel, input logic [31:0] exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        sbq.push_back(e);
    endtask

    task automatic sample();
        #1;
        -> sample_ev;
        #1;
    endtask

    task automatic do_write(input logic [4:0] addr, input logic [31:0] data);
        @(negedge clk);
        RegWrite = 1'b1;
        A3       = addr;
        WD3      = data;
        @(posedge clk);
        #1;
        RegWrite = 1'b0;
    endtask

    task automatic set_reads(input logic [4:0] r1, input logic [4:0] r2);
        A1 = r1;
        A2 = r2;
    endtask

    initial begin
        rst_n = 1'b1; RegWrite = 1'b0; A1 = '0; A2 = '0; A3 = '0; WD3 = '0;

        // asynchronous reset, mid-cycle, before any clock edge
        #2;
        set_reads(5'd2, 5'd5);
        #1 rst_n = 1'b0;
        push_exp("reset_rd1_sp", 0, SP);
        push_exp("reset_rd2_x5", 1, 32'h0);
        push_exp("reset_a0", 2, 32'h0);
        sample();

        // write attempted while reset is held must be ignored
        @(negedge clk);
        RegWrite = 1'b1; A3 = 5'd5; WD3 = 32'hCAFE_F00D;
        @(posedge clk);
        #1 RegWrite = 1'b0;
        set_reads(5'd5, 5'd0);
        push_exp("write_in_reset_x5", 0, 32'h0);
        push_exp("reset_x0", 1, 32'h0);
        sample();
        @(negedge clk) rst_n = 1'b1;

        // basic write / dual read of the same register
        do_write(5'd5, 32'hDEAD_BEEF);
        set_reads(5'd5, 5'd5);
        push_exp("basic_rd1", 0, 32'hDEAD_BEEF);
        push_exp("basic_rd2", 1, 32'hDEAD_BEEF);
        sample();

        // x0 protection
        do_write(5'd0, 32'hFFFF_FFFF);
        set_reads(5'd0, 5'd5);
        push_exp("x0_rd1", 0, 32'h0);
        push_exp("x0_no_alias_x5", 1, 32'hDEAD_BEEF);
        sample();

        // RegWrite low leaves state untouched
        @(negedge clk);
        RegWrite = 1'b0; A3 = 5'd5; WD3 = 32'h1234_5678;
        @(posedge clk);
        #1;
        set_reads(5'd5, 5'd2);
        push_exp("nowrite_x5", 0, 32'hDEAD_BEEF);
        push_exp("sp_kept", 1, SP);
        sample();

        // a0 tracks x10 only
        do_write(5'd10, 32'd42);
        push_exp("a0_after_x10", 2, 32'd42);
        sample();
        do_write(5'd11, 32'd7);
        set_reads(5'd11, 5'd10);
        push_exp("a0_after_x11", 2, 32'd42);
        push_exp("x11_rd1", 0, 32'd7);
        push_exp("x10_rd2", 1, 32'd42);
        sample();

        // same-cycle read of a register being written
        do_write(5'd6, 32'h1111_1111);
        @(negedge clk);
        RegWrite = 1'b1; A3 = 5'd6; WD3 = 32'h2222_2222;
        set_reads(5'd6, 5'd6);
`ifdef REGFILE_BYPASS_EN
        push_exp("same_cycle_rd1", 0, 32'h2222_2222);
        push_exp("same_cycle_rd2", 1, 32'h2222_2222);
`else
        push_exp("same_cycle_rd1", 0, 32'h1111_1111);
        push_exp("same_cycle_rd2", 1, 32'h1111_1111);
`endif
        sample();
        @(posedge clk);
        #1 RegWrite = 1'b0;
        push_exp("post_edge_rd1", 0, 32'h2222_2222);
        sample();

        // write to x0 never forwards, and a0 ignores any forwarding
        @(negedge clk);
        RegWrite = 1'b1; A3 = 5'd0; WD3 = 32'h7777_7777;
        set_reads(5'd0, 5'd6);
        push_exp("x0_no_bypass", 0, 32'h0);
        sample();
        A3 = 5'd10; WD3 = 32'd99;
        push_exp("a0_pre_edge", 2, 32'd42);
        sample();
        @(posedge clk);
        #1 RegWrite = 1'b0;
        push_exp("a0_post_edge", 2, 32'd99);
        sample();

        // reset coincident with a write to x7
        do_write(5'd7, 32'h55);
        set_reads(5'd7, 5'd2);
        push_exp("x7_before_reset", 0, 32'h55);
        sample();
        @(negedge clk);
        RegWrite = 1'b1; A3 = 5'd7; WD3 = 32'hAA;
        @(posedge clk);
        rst_n = 1'b0;
        #1 RegWrite = 1'b0;
        push_exp("x7_in_reset", 0, 32'h0);
        push_exp("sp_in_reset", 1, SP);
        push_exp("a0_in_reset", 2, 32'h0);
        sample();
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
        push_exp("x7_after_reset", 0, 32'h0);
        push_exp("sp_after_reset", 1, SP);
        sample();

        #2;
        if (sbq.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
